// File: rtl/spec_return_stack.sv
// -----------------------------------------------------------------------------
// spec_return_stack
// Return address stack for call/return prediction, built as a circular array
// of DEPTH entries addressed by a top pointer. When full, a push silently
// replaces the oldest entry and raises a one-cycle overflow pulse. A pop on an
// empty stack raises a one-cycle underflow pulse and changes nothing else.
//
// Optional feature macro: RAS_CHECKPOINT_EN
//   Defined   : adds the ckpt_save / ckpt_restore ports and one {tp, count}
//               snapshot register. Mispredicted speculation can then be rolled
//               back. Entries written after the save are not repaired.
//   Undefined : those ports and the snapshot register do not exist.
// -----------------------------------------------------------------------------
module spec_return_stack #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             return_addr,
    output logic [ADDR_W-1:0]             top_addr,
    output logic                          top_valid,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow
`ifdef RAS_CHECKPOINT_EN
    ,
    input  logic                          ckpt_save,
    input  logic                          ckpt_restore
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Pointer arithmetic; DEPTH is a power of two, so natural wrap is modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_ONE;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return p - PTR_ONE;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  tp_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              underflow_r;

    // Next-state and write-port controls
    logic [PTR_W-1:0]  tp_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic              ovf_nxt_s;
    logic              unf_nxt_s;
    logic              empty_s;
    logic              full_s;
    logic [PTR_W-1:0]  tp_inc_s;
    logic [PTR_W-1:0]  tp_dec_s;

`ifdef RAS_CHECKPOINT_EN
    logic [PTR_W-1:0]  ckpt_tp_r;
    logic [CNT_W-1:0]  ckpt_cnt_r;
`endif

    assign empty_s  = (count_r == CNT_ZERO);
    assign full_s   = (count_r == CNT_FULL);
    assign tp_inc_s = ptr_inc(tp_r);
    assign tp_dec_s = ptr_dec(tp_r);

    // ---------------------------------------------------------------------
    // Operation decode: push / pop / replace, with optional restore override
    // ---------------------------------------------------------------------
    // Next pointer, count, write port and status pulses from the request mix.
    always_comb begin
        tp_nxt_s    = tp_r;
        count_nxt_s = count_r;
        wr_en_s     = 1'b0;
        wr_ptr_s    = tp_r;
        ovf_nxt_s   = 1'b0;
        unf_nxt_s   = 1'b0;
`ifdef RAS_CHECKPOINT_EN
        if (ckpt_restore) begin
            // Restore overrides any concurrent push/pop, including its write.
            tp_nxt_s    = ckpt_tp_r;
            count_nxt_s = ckpt_cnt_r;
        end else begin
`else
        begin
`endif
            case ({push, pop})
                2'b10: begin
                    // Plain push: write above the top; when full this lands
                    // on the oldest entry.
                    wr_en_s  = 1'b1;
                    wr_ptr_s = tp_inc_s;
                    tp_nxt_s = tp_inc_s;
                    if (full_s) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = count_r + CNT_ONE;
                    end
                end
                2'b01: begin
                    // Plain pop: entry contents are left untouched.
                    if (empty_s) begin
                        unf_nxt_s = 1'b1;
                    end else begin
                        tp_nxt_s    = tp_dec_s;
                        count_nxt_s = count_r - CNT_ONE;
                    end
                end
                2'b11: begin
                    // Return followed by call: replace the top in place.
                    // On an empty stack this degenerates into a plain push.
                    wr_en_s = 1'b1;
                    if (empty_s) begin
                        wr_ptr_s    = tp_inc_s;
                        tp_nxt_s    = tp_inc_s;
                        count_nxt_s = CNT_ONE;
                    end else begin
                        wr_ptr_s    = tp_r;
                    end
                end
                default: begin
                    tp_nxt_s    = tp_r;
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // Pointer, occupancy and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tp_r        <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            tp_r        <= tp_nxt_s;
            count_r     <= count_nxt_s;
            overflow_r  <= ovf_nxt_s;
            underflow_r <= unf_nxt_s;
        end
    end

    // Entry storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en_s && reset_n) begin
            mem_r[wr_ptr_s] <= return_addr;
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

`ifdef RAS_CHECKPOINT_EN
    // Snapshot of the post-update pointer/count; a concurrent restore wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ckpt_tp_r  <= {PTR_W{1'b0}};
            ckpt_cnt_r <= CNT_ZERO;
        end else if (ckpt_save && !ckpt_restore) begin
            ckpt_tp_r  <= tp_nxt_s;
            ckpt_cnt_r <= count_nxt_s;
        end else begin
            ckpt_tp_r  <= ckpt_tp_r;
            ckpt_cnt_r <= ckpt_cnt_r;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Outputs: top view is combinational from registered state only
    // ---------------------------------------------------------------------
    assign top_valid = !empty_s;
    assign top_addr  = empty_s ? {ADDR_W{1'b0}} : mem_r[tp_r];
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_spec_return_stack.sv
// -----------------------------------------------------------------------------
// tb_spec_return_stack
// Directed bench for spec_return_stack with DEPTH = 4. A behavioural stack
// model tracks the expected outputs and is compared on every falling edge;
// hand-computed literal checks pin the key scenarios. Define
// RAS_CHECKPOINT_EN to include the checkpoint scenario.
// -----------------------------------------------------------------------------
module tb_spec_return_stack;

    localparam int AW = 32;
    localparam int D  = 4;

    logic          clk;
    logic          reset_n;
    logic          push;
    logic          pop;
    logic [AW-1:0] return_addr;
    logic [AW-1:0] top_addr;
    logic          top_valid;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;
    logic          ckpt_save;
    logic          ckpt_restore;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    spec_return_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push),
        .pop         (pop),
        .return_addr (return_addr),
        .top_addr    (top_addr),
        .top_valid   (top_valid),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef RAS_CHECKPOINT_EN
        ,
        .ckpt_save   (ckpt_save),
        .ckpt_restore(ckpt_restore)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_mem [D];
    int m_tp = 0, m_cnt = 0, m_ck_tp = 0, m_ck_cnt = 0;
    bit m_ovf = 1'b0, m_unf = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tp = 0; m_cnt = 0; m_ck_tp = 0; m_ck_cnt = 0;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
`ifdef RAS_CHECKPOINT_EN
            if (ckpt_restore) begin
                m_tp  = m_ck_tp;
                m_cnt = m_ck_cnt;
            end else begin
`else
            begin
`endif
                if (push && (!pop || m_cnt == 0)) begin
                    m_tp = (m_tp + 1) % D;
                    m_mem[m_tp] = return_addr;
                    if (m_cnt == D && !pop) m_ovf = 1'b1;
                    else m_cnt = m_cnt + 1;
                end else if (push && pop) begin
                    m_mem[m_tp] = return_addr;
                end else if (pop) begin
                    if (m_cnt == 0) m_unf = 1'b1;
                    else begin
                        m_tp  = (m_tp + D - 1) % D;
                        m_cnt = m_cnt - 1;
                    end
                end
`ifdef RAS_CHECKPOINT_EN
                if (ckpt_save) begin
                    m_ck_tp  = m_tp;
                    m_ck_cnt = m_cnt;
                end
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_top_addr",  top_addr, (m_cnt != 0) ? m_mem[m_tp] : '0);
            chk("model_top_valid", {31'd0, top_valid}, {31'd0, m_cnt != 0});
            chk("model_count",     {29'd0, count}, AW'(m_cnt));
            chk("model_overflow",  {31'd0, overflow}, {31'd0, m_ovf});
            chk("model_underflow", {31'd0, underflow}, {31'd0, m_unf});
        end
    end

    // One clock with the given request; returns at the following falling edge.
    task automatic op(input bit p, input bit q, input logic [AW-1:0] a,
                      input bit s, input bit r);
        push = p; pop = q; return_addr = a; ckpt_save = s; ckpt_restore = r;
        @(negedge clk);
        push = 1'b0; pop = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; return_addr = '0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("reset_count",     {29'd0, count}, 32'd0);
        chk("reset_top_valid", {31'd0, top_valid}, 32'd0);
        chk("reset_top_addr",  top_addr, 32'h0);

        // Basic push/pop
        op(1, 0, 32'h100, 0, 0);
        op(1, 0, 32'h200, 0, 0);
        op(1, 0, 32'h300, 0, 0);
        chk("push3_top", top_addr, 32'h300);
        chk("push3_count", {29'd0, count}, 32'd3);
        op(0, 1, '0, 0, 0);
        op(0, 1, '0, 0, 0);
        chk("pop2_top", top_addr, 32'h100);
        chk("pop2_count", {29'd0, count}, 32'd1);
        op(0, 1, '0, 0, 0);

        // Underflow on empty pop, exactly one cycle
        op(0, 1, '0, 0, 0);
        chk("unf_pulse", {31'd0, underflow}, 32'd1);
        chk("unf_count", {29'd0, count}, 32'd0);
        chk("unf_top", top_addr, 32'h0);
        op(0, 0, '0, 0, 0);
        chk("unf_clear", {31'd0, underflow}, 32'd0);

        // Overflow: five pushes into four entries
        for (int i = 0; i < 4; i++) op(1, 0, 32'hA + i, 0, 0);
        chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        op(1, 0, 32'hE, 0, 0);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop_top", top_addr, 32'hE - i);
            op(0, 1, '0, 0, 0);
        end
        chk("ovf_drained_valid", {31'd0, top_valid}, 32'd0);

        // Simultaneous push and pop replaces the top
        op(1, 0, 32'h30, 0, 0);
        op(1, 0, 32'h40, 0, 0);
        op(1, 1, 32'h80, 0, 0);
        chk("replace_top", top_addr, 32'h80);
        chk("replace_count", {29'd0, count}, 32'd2);
        op(0, 1, '0, 0, 0);
        chk("replace_below", top_addr, 32'h30);
        op(0, 1, '0, 0, 0);

        // Push+pop while empty behaves as a push, no underflow
        op(1, 1, 32'h55, 0, 0);
        chk("pp_empty_count", {29'd0, count}, 32'd1);
        chk("pp_empty_top", top_addr, 32'h55);
        chk("pp_empty_unf", {31'd0, underflow}, 32'd0);
        op(0, 1, '0, 0, 0);

`ifdef RAS_CHECKPOINT_EN
        // Checkpoint save/restore
        op(1, 0, 32'h10, 0, 0);
        op(0, 0, '0, 1, 0);
        op(1, 0, 32'h20, 0, 0);
        op(0, 1, '0, 0, 0);
        op(0, 1, '0, 0, 0);
        op(1, 0, 32'h99, 0, 1);
        chk("ckpt_top", top_addr, 32'h10);
        chk("ckpt_count", {29'd0, count}, 32'd1);
        op(1, 0, 32'h77, 1, 1);
        op(0, 0, '0, 0, 1);
        chk("ckpt_keep_count", {29'd0, count}, 32'd1);
        op(0, 1, '0, 0, 0);
`endif

        // Asynchronous reset mid-cycle while pushing into a full stack
        for (int i = 0; i < 4; i++) op(1, 0, 32'h200 + i, 0, 0);
        push = 1'b1; return_addr = 32'hDEAD;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_valid", {31'd0, top_valid}, 32'd0);
        chk("arst_top", top_addr, 32'h0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_unf", {31'd0, underflow}, 32'd0);
        @(negedge clk);
        push = 1'b0;
        reset_n = 1'b1;
        chk("arst_hold_count", {29'd0, count}, 32'd0);
        chk("arst_hold_ovf", {31'd0, overflow}, 32'd0);
        op(1, 0, 32'h123, 0, 0);
        chk("post_rst_top", top_addr, 32'h123);
        op(0, 0, '0, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spec_return_stack.md
SPEC_RETURN_STACK -- requirements
Module: spec_return_stack

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, return address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-003 The block SHALL have localparam PTR_W = log2(DEPTH) and localparam CNT_W = PTR_W+1.
REQ-004 Ports SHALL be:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- push  input  1  push return_addr this cycle
- pop  input  1  discard top entry this cycle
- return_addr  input  ADDR_W  address to push
- top_addr  output  ADDR_W  current top entry; 0 when empty
- top_valid  output  1  stack non-empty
- count  output  CNT_W  live entries, 0..DEPTH
- overflow  output  1  one-cycle pulse: push overwrote oldest entry
- underflow  output  1  one-cycle pulse: pop while empty
- ckpt_save  input  1  snapshot pointer/count (RAS_CHECKPOINT_EN only)
- ckpt_restore  input  1  reload snapshot (RAS_CHECKPOINT_EN only)

Function
REQ-005 Storage SHALL be a circular array of DEPTH entries, indexed by top pointer tp (PTR_W bits), wrapping modulo DEPTH.
REQ-006 top_addr and top_valid SHALL be combinational from registered state: entry[tp] and (count != 0); top_addr = 0 when count = 0.
REQ-007 A push alone SHALL write entry[tp+1] and advance tp by 1; count increments, saturating at DEPTH.
REQ-008 A push with count = DEPTH SHALL overwrite the oldest entry, keep count = DEPTH, and assert overflow for one cycle.
REQ-009 A pop alone with count > 0 SHALL decrement tp by 1 and count by 1; entry contents stay unchanged.
REQ-010 A pop alone with count = 0 SHALL leave tp and count unchanged and assert underflow for one cycle.
REQ-011 Push and pop together SHALL overwrite entry[tp] with return_addr, leaving tp and count unchanged.
REQ-012 If push and pop arrive together with count = 0, the block SHALL push the address (count becomes 1), with no underflow.
REQ-013 State changes SHALL take effect on the next rising clk edge, so top_addr reflects an operation one cycle after it.

Reset
REQ-014 reset_n low SHALL asynchronously clear tp, count, overflow, underflow and the checkpoint registers to 0; entry contents are not reset.
REQ-015 Reset assertion mid-operation SHALL cancel any same-cycle push, pop, save or restore; after reset, top_valid = 0 and top_addr = 0.

Configuration
REQ-016 With macro RAS_CHECKPOINT_EN defined, the block SHALL include the ckpt_save and ckpt_restore ports and one checkpoint register holding {tp, count}.
REQ-017 ckpt_save SHALL capture the post-update {tp, count} of the same cycle.
REQ-018 ckpt_restore SHALL load {tp, count} from the checkpoint and override any same-cycle push or pop.
REQ-019 If ckpt_save and ckpt_restore arrive together, restore SHALL win and the checkpoint SHALL stay unchanged.
REQ-020 Restore SHALL NOT repair entries overwritten after the save; those entries read as last written.
REQ-021 Without RAS_CHECKPOINT_EN, the checkpoint ports and register SHALL be absent and behaviour SHALL match REQ-005..REQ-015.

Verification
REQ-022 The bench SHALL cover: reset, then push 0x100, 0x200, 0x300 -> top_addr = 0x300, count = 3; pop twice -> top_addr = 0x100, count = 1.
REQ-023 The bench SHALL cover: DEPTH = 4, push 0xA..0xE (five pushes) -> overflow pulse on the 5th, count = 4; four pops return 0xE, 0xD, 0xC, 0xB; then top_valid = 0.
REQ-024 The bench SHALL cover: count = 0, pop -> underflow for exactly one cycle, count = 0, top_addr = 0.
REQ-025 The bench SHALL cover: top = 0x40, count = 2, push 0x80 with pop -> top_addr = 0x80, count = 2.
REQ-026 The bench SHALL cover, with RAS_CHECKPOINT_EN: push 0x10, save, push 0x20, pop, pop, restore -> top_addr = 0x10, count = 1.
REQ-027 The bench SHALL cover: reset_n driven low between clock edges while pushing -> count = 0 and top_valid = 0 immediately, with no overflow or underflow pulse.
